serial_logic_engine: RTL and testbench

Bit-serial 32-bit logic engine for the Lab3 ALU datapath. Accepts two WIDTH-bit operands and a 2-bit logic opcode over a valid/ready handshake. Streams the operands LSB-first through one instance of the existing 1-bit `logicunit`, one bit per clock, and assembles the WIDTH-bit result. It sits directly upstream of the 1-bit logic unit, driving its `a`, `b` and `control` inputs, and consumes that unit's `out`.

---
 rtl/serial_logic_pkg.sv | 15 +
 rtl/serial_logic_engine_logicunit.sv | 22 ++
 rtl/serial_logic_engine.sv | 118 +++++++++++
 tb/tb_serial_logic_engine.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_logic_pkg.sv
// Shared opcodes and FSM state type for the bit-serial logic engine.
package serial_logic_pkg;

  localparam logic [1:0] LU_AND = 2'b00;
  localparam logic [1:0] LU_OR  = 2'b01;
  localparam logic [1:0] LU_NOR = 2'b10;
  localparam logic [1:0] LU_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/serial_logic_engine_logicunit.sv
// 1-bit logic unit: AND / OR / NOR / XOR of a and b selected by control.
module logicunit
  import serial_logic_pkg::*;
(
  output logic       out,
  input  logic       a,
  input  logic       b,
  input  logic [1:0] control
);

  always_comb begin
    out = 1'b0;
    case (control)
      LU_AND:  out = a & b;
      LU_OR:   out = a | b;
      LU_NOR:  out = ~(a | b);
      LU_XOR:  out = a ^ b;
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_logic_engine.sv
// Bit-serial WIDTH-bit logic engine: streams operands LSB-first through one logicunit.
// Optional registered zero flag enabled by macro SERIAL_LOGIC_ZERO_FLAG_EN.
module serial_logic_engine
  import serial_logic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       ctrl_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] out_reg;
  logic             out_valid_reg;
  logic             lu_out;
  logic [WIDTH-1:0] res_next;
  logic             accept;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
  logic             zero_reg;
`endif

  logicunit u_logicunit (
    .out     (lu_out),
    .a       (a_reg[0]),
    .b       (b_reg[0]),
    .control (ctrl_reg)
  );

  // Each result bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  assign res_next  = {lu_out, res_reg[WIDTH-1:1]};
  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign out       = out_reg;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
  assign zero      = zero_reg;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      ctrl_reg      <= '0;
      res_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
      zero_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            ctrl_reg  <= control;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          res_reg <= res_next;
          if (cnt_reg == LAST) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            out_reg       <= res_next;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
            zero_reg      <= (res_next == '0);
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // Result consumed; a waiting request slips straight into RUN on the same edge.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            if (in_valid) begin
              a_reg     <= a;
              b_reg     <= b;
              ctrl_reg  <= control;
              cnt_reg   <= '0;
              state_reg <= RUN;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_logic_engine.sv
// Scoreboard bench for serial_logic_engine (WIDTH=32), zero checks follow SERIAL_LOGIC_ZERO_FLAG_EN.
module tb_serial_logic_engine;

  localparam int WIDTH = 32;

  logic              clock     = 1'b0;
  logic              reset     = 1'b1;
  logic              in_valid  = 1'b0;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  a         = '0;
  logic [WIDTH-1:0]  b         = '0;
  logic [1:0]        control   = '0;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
  logic              zero;
`endif

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  int accept_cyc = 0;
  logic [WIDTH-1:0] sb_q[$];

  serial_logic_engine #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives a request until accepted; pushes the expected result at the accept edge.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                      input logic [1:0] tc, input logic [WIDTH-1:0] exp, output bit timed_out);
    timed_out = 1'b1;
    a = ta; b = tb_v; control = tc; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        step();
        timed_out = 1'b0;
        break;
      end
      step();
    end
    in_valid = 1'b0;
    if (!timed_out) begin
      accept_cyc = cyc;
      sb_q.push_back(exp);
    end
  endtask

  task automatic wait_valid(output int lat, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
    lat = cyc - accept_cyc;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    assertions++;
    if (out_valid !== 1'b0 || out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got out_valid=%b out=%h, required 0 / 0", out_valid, out);
    end
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    assertions++;
    if (zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_zero: got %b, required 0", zero);
    end
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    step();
    assertions++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1 / 0", in_ready, out_valid);
    end
    $display("txn reset done");
  endtask

  task automatic test_and();
    bit to; int lat; logic [WIDTH-1:0] exp;
    send(32'hF0F01234, 32'hFF00FF00, 2'd0, 32'hF0001200, to);
    assertions++;
    if (to || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL and_accept: timeout=%b in_ready=%b, required 0 / 0", to, in_ready);
    end
    wait_valid(lat, to);
    exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
    assertions++;
    if (to || lat != 32) begin
      failures++;
      $display("FAIL and_latency: got %0d (timeout=%b), required 32", lat, to);
    end
    assertions++;
    if (out !== exp) begin
      failures++;
      $display("FAIL and_out: got %h, required %h", out, exp);
    end
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    assertions++;
    if (zero !== 1'b0) begin
      failures++;
      $display("FAIL and_zero: got %b, required 0", zero);
    end
`endif
    $display("txn AND a=f0f01234 b=ff00ff00 out=%h lat=%0d", out, lat);
    step();
    assertions++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL and_consume: got out_valid=%b in_ready=%b, required 0 / 1", out_valid, in_ready);
    end
  endtask

  task automatic test_or_nor();
    logic [WIDTH-1:0] ta [3] = '{32'h000000FF, 32'hFFFFFFFF, 32'h00000000};
    logic [WIDTH-1:0] tbv[3] = '{32'h0F000000, 32'h00000000, 32'h00000000};
    logic [1:0]       tc [3] = '{2'd1, 2'd2, 2'd2};
    logic [WIDTH-1:0] te [3] = '{32'h0F0000FF, 32'h00000000, 32'hFFFFFFFF};
    for (int k = 0; k < 3; k++) begin
      bit to; int lat; logic [WIDTH-1:0] exp;
      send(ta[k], tbv[k], tc[k], te[k], to);
      wait_valid(lat, to);
      exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
      assertions++;
      if (to || lat != 32 || out !== exp) begin
        failures++;
        $display("FAIL or_nor_%0d: got out=%h lat=%0d timeout=%b, required out=%h lat=32", k, out, lat, to, exp);
      end
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
      assertions++;
      if (zero !== (exp == '0)) begin
        failures++;
        $display("FAIL or_nor_zero_%0d: got %b, required %b", k, zero, (exp == '0));
      end
`endif
      $display("txn op=%0d a=%h b=%h out=%h lat=%0d", tc[k], ta[k], tbv[k], out, lat);
      step();
    end
  endtask

  task automatic test_mid_reset();
    bit to; int lat; logic [WIDTH-1:0] exp;
    send(32'hDEADBEEF, 32'hFFFFFFFF, 2'd0, 32'hDEADBEEF, to);
    repeat (11) step();
    reset = 1'b0;
    #1;
    assertions++;
    if (out_valid !== 1'b0 || out !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: got out_valid=%b out=%h in_ready=%b, required 0 / 0 / 1", out_valid, out, in_ready);
    end
    sb_q.delete();
    @(negedge clock);
    reset = 1'b1;
    step();
    assertions++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_release: got in_ready=%b out_valid=%b, required 1 / 0", in_ready, out_valid);
    end
    $display("txn AND aborted by reset");
    send(32'h00000001, 32'h00000002, 2'd1, 32'h00000003, to);
    wait_valid(lat, to);
    exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
    assertions++;
    if (to || lat != 32 || out !== exp) begin
      failures++;
      $display("FAIL post_reset_or: got out=%h lat=%0d timeout=%b, required %h lat=32", out, lat, to, exp);
    end
    $display("txn OR a=00000001 b=00000002 out=%h lat=%0d", out, lat);
    step();
  endtask

  task automatic test_back_to_back();
    bit to; int lat; int first_cyc; logic [WIDTH-1:0] exp;
    send(32'hAAAA0000, 32'h0000AAAA, 2'd3, 32'hAAAAAAAA, to);
    wait_valid(lat, to);
    first_cyc = cyc;
    exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
    assertions++;
    if (to || out !== exp) begin
      failures++;
      $display("FAIL b2b_first: got out=%h timeout=%b, required %h", out, to, exp);
    end
    $display("txn XOR a=aaaa0000 b=0000aaaa out=%h lat=%0d", out, lat);
    a = 32'h12345678; b = 32'h12345678; control = 2'd3; in_valid = 1'b1;
    #1;
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_in_ready: got %b, required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    accept_cyc = cyc;
    sb_q.push_back(32'h00000000);
    assertions++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: got out_valid=%b in_ready=%b, required 0 / 0", out_valid, in_ready);
    end
    wait_valid(lat, to);
    exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
    assertions++;
    if (to || lat != 32 || (cyc - first_cyc) != 33) begin
      failures++;
      $display("FAIL b2b_timing: got lat=%0d period=%0d timeout=%b, required 32 / 33", lat, cyc - first_cyc, to);
    end
    assertions++;
    if (out !== exp) begin
      failures++;
      $display("FAIL b2b_out: got %h, required %h", out, exp);
    end
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    assertions++;
    if (zero !== 1'b1) begin
      failures++;
      $display("FAIL b2b_zero: got %b, required 1", zero);
    end
`endif
    $display("txn XOR a=12345678 b=12345678 out=%h lat=%0d", out, lat);
    step();
  endtask

  task automatic test_xor_backpressure();
    bit to; int lat; logic [WIDTH-1:0] exp;
    out_ready = 1'b0;
    send(32'hAAAAAAAA, 32'h55555555, 2'd3, 32'hFFFFFFFF, to);
    wait_valid(lat, to);
    exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
    assertions++;
    if (to || lat != 32) begin
      failures++;
      $display("FAIL bp_latency: got %0d (timeout=%b), required 32", lat, to);
    end
    for (int i = 0; i < 5; i++) begin
      assertions++;
      if (out_valid !== 1'b1 || out !== exp || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: got out_valid=%b out=%h in_ready=%b, required 1 / %h / 0", i, out_valid, out, in_ready, exp);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    assertions++;
    if (out !== exp || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got out=%h out_valid=%b, required %h / 1", out, out_valid, exp);
    end
    $display("txn XOR a=aaaaaaaa b=55555555 out=%h held 5 cycles", out);
    step();
    assertions++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== exp) begin
      failures++;
      $display("FAIL bp_consumed: got out_valid=%b in_ready=%b out=%h, required 0 / 1 / %h", out_valid, in_ready, out, exp);
    end
  endtask

  task automatic test_operand_change();
    bit to; int lat; logic [WIDTH-1:0] exp;
    send(32'hFFFF0000, 32'h0FF00FF0, 2'd0, 32'h0FF00000, to);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        to = 1'b0;
        break;
      end
      a = $urandom; b = $urandom; control = 2'($urandom_range(0, 3));
      step();
    end
    lat = cyc - accept_cyc;
    exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
    assertions++;
    if (to || lat != 32 || out !== exp) begin
      failures++;
      $display("FAIL operand_change: got out=%h lat=%0d timeout=%b, required %h lat=32", out, lat, to, exp);
    end
    $display("txn AND a=ffff0000 b=0ff00ff0 (inputs toggled) out=%h lat=%0d", out, lat);
    step();
  endtask

  initial begin
    test_reset();
    test_and();
    test_or_nor();
    test_mid_reset();
    test_back_to_back();
    test_xor_backpressure();
    test_operand_change();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
